mul_share_arbiter: RTL
======================

# mul_share_arbiter

Two-port arbiter and sequencer that shares a single column bypass multiplier between the dual-issue pipes (pipe 0, pipe 1). It accepts multiply requests over valid/ready handshakes, grants round-robin, and launches one operation at a time. It tracks the in-flight owner, routes the multiplier result back to the issuing pipe, and supports flush of an in-flight operation. An optional operand-swap stage steers the sparser operand onto the multiplier's column input to cut latency.

## Interface
Parameters:
- None.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req0_valid_i / req1_valid_i  in  1  request from pipe 0 / pipe 1
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle when valid&ready
- req0_op_a_i, req0_op_b_i / req1_op_a_i, req1_op_b_i  in  32  operands
- req0_rd_idx_i / req1_rd_idx_i  in  5  destination register
- flush_i  in  1  discard in-flight and same-cycle results
- mul_start_o  out  1  start pulse to multiplier
- mul_op_a_o, mul_op_b_o  out  32  multiplier operands (op_a = column/bypass operand)
- mul_rd_idx_o  out  5  destination index to multiplier
- mul_done_i  in  1  multiplier done pulse
- mul_result_i  in  32  multiplier result
- mul_result_rd_idx_i  in  5  multiplier result destination
- resp0_valid_o / resp1_valid_o  out  1  one-cycle result pulse to pipe 0 / pipe 1
- resp_result_o  out  32  result (shared by both pipes)
- resp_rd_idx_o  out  5  result destination (shared by both pipes)

## Operation
- States: IDLE (no op in flight), WAIT (op in flight, result wanted), DRAIN (op in flight, result discarded).
- can_issue = !flush_i && (state==IDLE || mul_done_i).
- Grant: one valid requester → it wins. Both valid → round-robin; the pointer last_grant_q names the most recent winner, and the other pipe wins. After reset last_grant_q=1, so pipe 0 wins the first tie.
- reqN_ready_o = can_issue && granted(N). Both ready signals are never high together. Ready is combinational from valid, state, mul_done_i and flush_i.
- On acceptance:
  - mul_start_o=1; operands and rd are muxed combinationally from the winner.
  - owner_q ← winner; last_grant_q ← winner; state → WAIT.
- Transitions:
  - IDLE + accept → WAIT.
  - WAIT + mul_done_i + !flush_i → capture response for owner_q. Next state is WAIT (new owner) if a same-cycle accept occurs, else IDLE.
  - WAIT + flush_i → DRAIN. If mul_done_i is in the same cycle, go straight to IDLE and suppress the response.
  - DRAIN + mul_done_i → no response. Next state is WAIT if a same-cycle accept occurs (only when !flush_i), else IDLE.
- mul_done_i in IDLE is ignored.
- Response: registered. The cycle after a captured done, resp{owner}_valid_o=1, resp_result_o=mul_result_i, resp_rd_idx_o=mul_result_rd_idx_i. resp_result_o and resp_rd_idx_o hold their values until the next response.
- Multiplier start is accepted only in its idle state; the arbiter never asserts mul_start_o while an op is in flight (except the mul_done_i cycle).

## Timing
- Reset values: all ready/valid/start outputs 0; mul_op_*, mul_rd_idx_o, resp_result_o, resp_rd_idx_o = 0; state IDLE; owner_q=0; last_grant_q=1.
- Acceptance at cycle T → resp pulse at T+N+3, where N = popcount(mul_op_a_o) (N=0 gives T+3).
- Back-to-back issue is possible: the next accept coincides with mul_done_i of the previous op, so there are zero idle cycles between multiplier ops.
- flush_i blocks acceptance in its own cycle.
- rst_i mid-operation: the arbiter returns to IDLE immediately. The multiplier shares rst_i, so no stale done arrives.

## Configuration
- MUL_SHARE_ARB_OPSWAP_EN defined:
  - If popcount(op_a) > popcount(op_b), operands are swapped onto mul_op_a_o/mul_op_b_o; on equality there is no swap.
  - The low-32 product is unchanged.
  - Latency uses N = min(popcount(a), popcount(b)).
- Not defined: operands pass straight through. No popcount logic is synthesized.

## Test plan
- Single req0 with a=0x0000_0005, b=7 → start at T; resp0_valid_o at T+5; result 35; rd echoed.
- Both valid every cycle from reset → grants alternate 0,1,0,1. Each next accept coincides with mul_done_i. Responses go to the correct pipe with correct rd.
- req1 with a=0, b=0xFFFF_FFFF → resp1_valid_o at T+3, result 0.
- Flush two cycles after accept (a=0xFF) → no response. A req0 asserted during DRAIN is accepted in the mul_done_i cycle, then completes normally.
- flush_i coincident with mul_done_i and req0_valid_i → no response, req0_ready_o=0, state IDLE; req0 accepted next cycle.
- a=0xFFFF_FFFF, b=3:
  - With MUL_SHARE_ARB_OPSWAP_EN: mul_op_a_o=3, resp at T+5, result 0xFFFF_FFFD.
  - Without it: resp at T+35, same result.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Shares one column-bypass multiplier between pipe 0 and pipe 1 with round-robin grant and in-order result routing.
// Optional operand swap (sparser operand onto the column input) is enabled by defining MUL_SHARE_ARB_OPSWAP_EN.
module mul_share_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_op_a_i,
    input  logic [31:0] req0_op_b_i,
    input  logic [4:0]  req0_rd_idx_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_op_a_i,
    input  logic [31:0] req1_op_b_i,
    input  logic [4:0]  req1_rd_idx_i,
    input  logic        flush_i,
    output logic        mul_start_o,
    output logic [31:0] mul_op_a_o,
    output logic [31:0] mul_op_b_o,
    output logic [4:0]  mul_rd_idx_o,
    input  logic        mul_done_i,
    input  logic [31:0] mul_result_i,
    input  logic [4:0]  mul_result_rd_idx_i,
    output logic        resp0_valid_o,
    output logic        resp1_valid_o,
    output logic [31:0] resp_result_o,
    output logic [4:0]  resp_rd_idx_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

    state_t      state_q, state_d;
    logic        owner_q;
    logic        last_grant_q;
    logic        winner;
    logic        any_valid;
    logic        can_issue;
    logic        accept;
    logic        capture;
    logic        swap_ops;
    logic [31:0] win_a, win_b;
    logic [4:0]  win_rd;

`ifdef MUL_SHARE_ARB_OPSWAP_EN
    function automatic logic [5:0] popcnt32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // Latency scales with the column operand's set bits, so put the sparser one there.
    assign swap_ops = popcnt32(win_a) > popcnt32(win_b);
`else
    assign swap_ops = 1'b0;
`endif

    assign any_valid = req0_valid_i | req1_valid_i;
    assign can_issue = !flush_i && ((state_q == ST_IDLE) || mul_done_i);
    assign accept    = can_issue && any_valid;

    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            winner = ~last_grant_q;
        end else begin
            winner = req1_valid_i;
        end
    end

    assign win_a  = winner ? req1_op_a_i   : req0_op_a_i;
    assign win_b  = winner ? req1_op_b_i   : req0_op_b_i;
    assign win_rd = winner ? req1_rd_idx_i : req0_rd_idx_i;

    assign req0_ready_o = accept && !winner;
    assign req1_ready_o = accept &&  winner;

    // Operand bus is held at zero unless a start is issued this cycle.
    assign mul_start_o  = accept;
    assign mul_op_a_o   = accept ? (swap_ops ? win_b : win_a) : 32'd0;
    assign mul_op_b_o   = accept ? (swap_ops ? win_a : win_b) : 32'd0;
    assign mul_rd_idx_o = accept ? win_rd : 5'd0;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = mul_done_i ? ST_IDLE : ST_DRAIN;
                end else if (mul_done_i) begin
                    capture = 1'b1;
                    state_d = accept ? ST_WAIT : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mul_done_i) begin
                    state_d = accept ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= winner;
                last_grant_q <= winner;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp0_valid_o <= 1'b0;
            resp1_valid_o <= 1'b0;
            resp_result_o <= 32'd0;
            resp_rd_idx_o <= 5'd0;
        end else begin
            resp0_valid_o <= capture && !owner_q;
            resp1_valid_o <= capture &&  owner_q;
            if (capture) begin
                resp_result_o <= mul_result_i;
                resp_rd_idx_o <= mul_result_rd_idx_i;
            end
        end
    end

endmodule
